// File: rtl/fpu_pkg.sv
// Shared binary32 definitions for the sequential FPU datapaths (divider FSM states, field widths, constants).
// Pure declarations: no logic, no latency, no flow control.
package fpu_pkg;

    localparam int FP_BIAS = 127;
    localparam int EXP_MAX = 255;
    localparam logic [31:0] CANON_NAN = 32'hFFC00000;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int MANT_W = 24;
    localparam int SEXP_W = 10;
    localparam int QBITS  = 28;

    typedef logic signed [SEXP_W-1:0] sexp_t;

    localparam sexp_t E_SPECIAL = 10'sd128;
    localparam sexp_t E_DENORM  = -10'sd127;
    localparam sexp_t E_MIN     = -10'sd126;
    localparam sexp_t E_MAX     = 10'sd127;
    localparam sexp_t E_ONE     = 10'sd1;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    typedef enum logic [3:0] {
        S_WAIT,
        S_UNPACK,
        S_SPECIAL,
        S_NORM_A,
        S_NORM_B,
        S_DIV_INIT,
        S_DIV_LOOP,
        S_DIV_GRS,
        S_NORM_1,
        S_NORM_2,
        S_ROUND,
        S_PACK,
        S_READY
    } div_state_t;

    function automatic sexp_t unbias(input logic [EXP_W-1:0] e);
        return sexp_t'({2'b00, e}) - sexp_t'(FP_BIAS);
    endfunction

endpackage

// File: rtl/fpu_div_iter.sv
// Restoring mantissa divider: one quotient bit per clock, QBITS clocks after start; done flags the last step.
// No backpressure: start reloads unconditionally, results hold until the next start.
module fpu_div_iter
    import fpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [MANT_W-1:0] a_m,
    input  logic [MANT_W-1:0] b_m,
    output logic [QBITS-1:0]  q,
    output logic              rem_nz,
    output logic              done
);
    localparam int CNT_W = $clog2(QBITS + 1);

    logic [MANT_W:0]  r_q, r_d;
    logic [QBITS-1:0] q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [MANT_W:0]  b_ext;
    logic [MANT_W:0]  r_sub;
    logic             ge;

    always_comb begin
        b_ext  = {1'b0, b_m};
        ge     = (r_q >= b_ext);
        r_sub  = ge ? (r_q - b_ext) : r_q;
        done   = busy_q && (cnt_q == CNT_W'(QBITS - 1));
        r_d    = r_q;
        q_d    = q_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start) begin
            r_d    = {1'b0, a_m};
            q_d    = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            // partial remainder stays below b_m, so the doubling never loses its top bit
            q_d   = {q_q[QBITS-2:0], ge};
            r_d   = r_sub << 1;
            cnt_d = cnt_q + 1'b1;
            if (done) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q    <= '0;
            q_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            r_q    <= r_d;
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign q      = q_q;
    assign rem_nz = (r_q != '0);

endmodule

// File: rtl/fpu_div_seq.sv
// Sequential binary32 divider (RNE). Latency 3 clks for specials, 39+ clks for finite operands.
// No backpressure: valid is sampled only when idle; ready is a one-cycle pulse with the new result.
module fpu_div_seq
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] din1,
    input  logic [31:0] din2,
    input  logic        valid,
    output logic [31:0] result,
    output logic        ready
);
    div_state_t        state_q, state_d;
    fp32_t             din1_q, din1_d, din2_q, din2_d;
    logic              a_s_q, a_s_d, b_s_q, b_s_d, z_s_q, z_s_d;
    sexp_t             a_e_q, a_e_d, b_e_q, b_e_d, z_e_q, z_e_d;
    logic [MANT_W-1:0] a_m_q, a_m_d, b_m_q, b_m_d, z_m_q, z_m_d;
    logic              guard_q, guard_d, round_q, round_d, sticky_q, sticky_d;
    logic [31:0]       z_q, z_d, result_q, result_d;
    logic              ready_q, ready_d;
    logic              iter_start, iter_done, iter_rem_nz;
    logic [QBITS-1:0]  iter_q;
    logic              a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
    logic [EXP_W-1:0]  exp_f;

    assign a_nan  = (a_e_q == E_SPECIAL) && (a_m_q[FRAC_W-1:0] != '0);
    assign a_inf  = (a_e_q == E_SPECIAL) && (a_m_q[FRAC_W-1:0] == '0);
    assign a_zero = (a_e_q == E_DENORM) && (a_m_q == '0);
    assign b_nan  = (b_e_q == E_SPECIAL) && (b_m_q[FRAC_W-1:0] != '0);
    assign b_inf  = (b_e_q == E_SPECIAL) && (b_m_q[FRAC_W-1:0] == '0);
    assign b_zero = (b_e_q == E_DENORM) && (b_m_q == '0);

    fpu_div_iter u_iter (
        .clk    (clk),
        .reset  (reset),
        .start  (iter_start),
        .a_m    (a_m_q),
        .b_m    (b_m_q),
        .q      (iter_q),
        .rem_nz (iter_rem_nz),
        .done   (iter_done)
    );

    always_comb begin
        state_d    = state_q;
        din1_d     = din1_q;
        din2_d     = din2_q;
        a_s_d      = a_s_q;
        a_e_d      = a_e_q;
        a_m_d      = a_m_q;
        b_s_d      = b_s_q;
        b_e_d      = b_e_q;
        b_m_d      = b_m_q;
        z_s_d      = z_s_q;
        z_e_d      = z_e_q;
        z_m_d      = z_m_q;
        guard_d    = guard_q;
        round_d    = round_q;
        sticky_d   = sticky_q;
        z_d        = z_q;
        result_d   = result_q;
        ready_d    = 1'b0;
        iter_start = 1'b0;
        exp_f      = '0;

        case (state_q)
            S_WAIT: begin
                if (valid) begin
                    din1_d  = din1;
                    din2_d  = din2;
                    state_d = S_UNPACK;
                end
            end
            S_UNPACK: begin
                a_m_d   = {1'b0, din1_q.frac};
                a_e_d   = unbias(din1_q.exp);
                a_s_d   = din1_q.sign;
                b_m_d   = {1'b0, din2_q.frac};
                b_e_d   = unbias(din2_q.exp);
                b_s_d   = din2_q.sign;
                state_d = S_SPECIAL;
            end
            S_SPECIAL: begin
                state_d = S_READY;
                if (a_nan || b_nan) begin
                    z_d = CANON_NAN;
                end else if ((a_inf && b_inf) || (a_zero && b_zero)) begin
                    z_d = CANON_NAN;
                end else if (a_inf || b_zero) begin
                    z_d = {a_s_q ^ b_s_q, 8'hFF, 23'h0};
                end else if (b_inf || a_zero) begin
                    z_d = {a_s_q ^ b_s_q, 31'h0};
                end else begin
                    state_d = S_NORM_A;
                    if (a_e_q == E_DENORM) a_e_d = E_MIN;
                    else                   a_m_d[MANT_W-1] = 1'b1;
                    if (b_e_q == E_DENORM) b_e_d = E_MIN;
                    else                   b_m_d[MANT_W-1] = 1'b1;
                end
            end
            S_NORM_A: begin
                if (a_m_q[MANT_W-1]) begin
                    state_d = S_NORM_B;
                end else begin
                    a_m_d = a_m_q << 1;
                    a_e_d = a_e_q - E_ONE;
                end
            end
            S_NORM_B: begin
                if (b_m_q[MANT_W-1]) begin
                    state_d = S_DIV_INIT;
                end else begin
                    b_m_d = b_m_q << 1;
                    b_e_d = b_e_q - E_ONE;
                end
            end
            S_DIV_INIT: begin
                z_s_d      = a_s_q ^ b_s_q;
                z_e_d      = a_e_q - b_e_q;
                iter_start = 1'b1;
                state_d    = S_DIV_LOOP;
            end
            S_DIV_LOOP: begin
                if (iter_done) state_d = S_DIV_GRS;
            end
            S_DIV_GRS: begin
                z_m_d    = iter_q[QBITS-1:4];
                guard_d  = iter_q[3];
                round_d  = iter_q[2];
                sticky_d = (|iter_q[1:0]) | iter_rem_nz;
                state_d  = S_NORM_1;
            end
            S_NORM_1: begin
                // quotient of two normalised mantissas is above 0.5, so at most one shift occurs
                if (!z_m_q[MANT_W-1]) begin
                    z_m_d   = {z_m_q[MANT_W-2:0], guard_q};
                    guard_d = round_q;
                    round_d = 1'b0;
                    z_e_d   = z_e_q - E_ONE;
                end else begin
                    state_d = S_NORM_2;
                end
            end
            S_NORM_2: begin
                if (z_e_q < E_MIN) begin
                    z_m_d    = z_m_q >> 1;
                    guard_d  = z_m_q[0];
                    round_d  = guard_q;
                    sticky_d = sticky_q | round_q;
                    z_e_d    = z_e_q + E_ONE;
                end else begin
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                if (guard_q && (round_q || sticky_q || z_m_q[0])) begin
                    z_m_d = z_m_q + 1'b1;
                    if (z_m_q == 24'hFFFFFF) z_e_d = z_e_q + E_ONE;
                end
                state_d = S_PACK;
            end
            S_PACK: begin
                state_d = S_READY;
                if (z_e_q > E_MAX) begin
                    z_d = {z_s_q, 8'hFF, 23'h0};
                end else begin
                    exp_f = (z_e_q == E_MIN && !z_m_q[MANT_W-1]) ? 8'h00
                                                                 : z_e_q[EXP_W-1:0] + 8'(FP_BIAS);
                    z_d   = {z_s_q, exp_f, z_m_q[FRAC_W-1:0]};
                end
            end
            S_READY: begin
                result_d = z_q;
                ready_d  = 1'b1;
                state_d  = S_WAIT;
            end
            default: state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_WAIT;
            din1_q   <= '0;
            din2_q   <= '0;
            a_s_q    <= 1'b0;
            a_e_q    <= '0;
            a_m_q    <= '0;
            b_s_q    <= 1'b0;
            b_e_q    <= '0;
            b_m_q    <= '0;
            z_s_q    <= 1'b0;
            z_e_q    <= '0;
            z_m_q    <= '0;
            guard_q  <= 1'b0;
            round_q  <= 1'b0;
            sticky_q <= 1'b0;
            z_q      <= '0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            din1_q   <= din1_d;
            din2_q   <= din2_d;
            a_s_q    <= a_s_d;
            a_e_q    <= a_e_d;
            a_m_q    <= a_m_d;
            b_s_q    <= b_s_d;
            b_e_q    <= b_e_d;
            b_m_q    <= b_m_d;
            z_s_q    <= z_s_d;
            z_e_q    <= z_e_d;
            z_m_q    <= z_m_d;
            guard_q  <= guard_d;
            round_q  <= round_d;
            sticky_q <= sticky_d;
            z_q      <= z_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign result = result_q;
    assign ready  = ready_q;

endmodule

// File: tb/tb_fpu_div_seq.sv
// Directed bench for fpu_div_seq: hand-computed quotients, latencies, reset abort and busy-time input isolation.
module tb_fpu_div_seq;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] din1;
    logic [31:0] din2;
    logic        valid;
    logic [31:0] result;
    logic        ready;

    int checks = 0;
    int errors = 0;

    fpu_div_seq dut (
        .clk    (clk),
        .reset  (reset),
        .din1   (din1),
        .din2   (din2),
        .valid  (valid),
        .result (result),
        .ready  (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; the next edge samples the request.
    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        din1  = a;
        din2  = b;
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic wait_ready(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!ready && lat < 400);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat, input string tag);
        int lat;
        launch(a, b);
        wait_ready(lat);
        check({tag, " result"}, result, exp_res);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        @(posedge clk);
        #1;
        check({tag, " pulse"}, {31'h0, ready}, 32'h0);
    endtask

    initial begin
        int lat;
        int pulses;
        reset = 1'b1;
        valid = 1'b0;
        din1  = '0;
        din2  = '0;
        #23;
        check("reset ready", {31'h0, ready}, 32'h0);
        check("reset result", result, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        run_op(32'h40C00000, 32'h40000000, 32'h40400000, 39, "6/2");
        run_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 40, "1/3");
        run_op(32'h3F800000, 32'h3F800000, 32'h3F800000, 39, "1/1");

        run_op(32'h3F800000, 32'h00000000, 32'h7F800000, 3, "1/0");
        run_op(32'hBF800000, 32'h00000000, 32'hFF800000, 3, "-1/0");
        run_op(32'h00000000, 32'h00000000, 32'hFFC00000, 3, "0/0");
        run_op(32'h7F800000, 32'h7F800000, 32'hFFC00000, 3, "inf/inf");
        run_op(32'h7FC00001, 32'h40000000, 32'hFFC00000, 3, "nan/x");
        run_op(32'h3F800000, 32'h7FC00000, 32'hFFC00000, 3, "x/nan");
        run_op(32'hFF800000, 32'h40000000, 32'hFF800000, 3, "-inf/2");
        run_op(32'hC0000000, 32'h7F800000, 32'h80000000, 3, "-2/inf");
        run_op(32'h00000000, 32'h40400000, 32'h00000000, 3, "0/3");

        run_op(32'h00800000, 32'h40000000, 32'h00400000, 40, "subnormal out");
        run_op(32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 39, "overflow");
        run_op(32'h00000001, 32'h00000001, 32'h3F800000, 85, "subnormal in");
        run_op(32'h40C00000, 32'h40000000, 32'h40400000, 39, "pre-reset 6/2");

        // Abort mid-loop: outputs clear at once and the aborted op never completes.
        launch(32'h3F800000, 32'h40400000);
        repeat (15) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("abort ready", {31'h0, ready}, 32'h0);
        check("abort result", result, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (ready) pulses++;
        end
        check("abort no output", 32'(pulses), 32'h0);
        check("abort result held", result, 32'h0);
        run_op(32'h40C00000, 32'h40000000, 32'h40400000, 39, "post-reset 6/2");

        // Requests while busy must be ignored.
        launch(32'h40C00000, 32'h40000000);
        pulses = 0;
        lat    = 0;
        for (int i = 1; i <= 70; i++) begin
            if (i <= 36) begin
                valid = i[0];
                din1  = 32'h3F800000;
                din2  = 32'h40400000;
            end else begin
                valid = 1'b0;
            end
            @(posedge clk);
            #1;
            if (ready) begin
                pulses++;
                if (pulses == 1) lat = i;
            end
        end
        check("busy pulses", 32'(pulses), 32'h1);
        check("busy latency", 32'(lat), 32'd39);
        check("busy result", result, 32'h40400000);

        // Back-to-back: next request presented in the ready cycle.
        launch(32'h3F800000, 32'h3F800000);
        wait_ready(lat);
        check("b2b first result", result, 32'h3F800000);
        check("b2b first latency", 32'(lat), 32'd39);
        launch(32'h40C00000, 32'h40000000);
        check("b2b single pulse", {31'h0, ready}, 32'h0);
        wait_ready(lat);
        check("b2b second result", result, 32'h40400000);
        check("b2b second latency", 32'(lat), 32'd39);
        @(posedge clk);
        #1;
        check("b2b second pulse", {31'h0, ready}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
